// File: rtl/mem_arbiter.sv
// Two-master arbiter onto a simple dual-port RAM (one write port, one read port), ports arbitrated independently.
// Latency: grants and memory strobes are combinational; read data returns one cycle after the read grant.
// Backpressure: a losing master sees gnt=0 and must hold req; contention policy is fixed master-0 priority or, with ARB_ROUND_ROBIN_EN, a per-port round-robin pointer.
module mem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_ena,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    output logic              mem_enb,
    output logic [ADDR_W-1:0] mem_addrb,
    input  logic [DATA_W-1:0] mem_doutb,
    output logic              mem_rstb
);

    logic wr_req0, wr_req1, rd_req0, rd_req1;
    logic wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;
    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;

    // Requests are masked by reset so nothing is granted while rst_n is low.
    assign wr_req0 = rst_n & m0_req & m0_we;
    assign wr_req1 = rst_n & m1_req & m1_we;
    assign rd_req0 = rst_n & m0_req & ~m0_we;
    assign rd_req1 = rst_n & m1_req & ~m1_we;

`ifdef ARB_ROUND_ROBIN_EN
    logic wr_ptr_q, wr_ptr_d;
    logic rd_ptr_q, rd_ptr_d;

    // Pointer names the master that wins the next contention; it flips to the loser.
    assign wr_gnt0  = wr_req0 & (~wr_req1 | ~wr_ptr_q);
    assign wr_gnt1  = wr_req1 & (~wr_req0 |  wr_ptr_q);
    assign rd_gnt0  = rd_req0 & (~rd_req1 | ~rd_ptr_q);
    assign rd_gnt1  = rd_req1 & (~rd_req0 |  rd_ptr_q);
    assign wr_ptr_d = (wr_req0 & wr_req1) ? ~wr_ptr_q : wr_ptr_q;
    assign rd_ptr_d = (rd_req0 & rd_req1) ? ~rd_ptr_q : rd_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
`else
    assign wr_gnt0 = wr_req0;
    assign wr_gnt1 = wr_req1 & ~wr_req0;
    assign rd_gnt0 = rd_req0;
    assign rd_gnt1 = rd_req1 & ~rd_req0;
`endif

    assign m0_gnt = wr_gnt0 | rd_gnt0;
    assign m1_gnt = wr_gnt1 | rd_gnt1;

    assign mem_ena   = wr_gnt0 | wr_gnt1;
    assign mem_wea   = wr_gnt0 | wr_gnt1;
    assign mem_addra = wr_gnt0 ? m0_addr  : (wr_gnt1 ? m1_addr  : '0);
    assign mem_dina  = wr_gnt0 ? m0_wdata : (wr_gnt1 ? m1_wdata : '0);

    assign mem_enb   = rd_gnt0 | rd_gnt1;
    assign mem_addrb = rd_gnt0 ? m0_addr : (rd_gnt1 ? m1_addr : '0);
    assign mem_rstb  = ~rst_n;

    // Response tracker tracks the RAM's one-cycle read latency.
    assign rd_pend_d  = rd_gnt0 | rd_gnt1;
    assign rd_owner_d = rd_gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0_rvalid = rd_pend_q & ~rd_owner_q;
    assign m1_rvalid = rd_pend_q &  rd_owner_q;
    assign m0_rdata  = m0_rvalid ? mem_doutb : '0;
    assign m1_rdata  = m1_rvalid ? mem_doutb : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural write-through dual-port RAM model.
module tb_mem_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_ena, mem_wea, mem_enb, mem_rstb;
    logic [AW-1:0] mem_addra, mem_addrb;
    logic [DW-1:0] mem_dina, mem_doutb;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] ram [512];
    int exp_w;
    int prev_w;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
        .mem_enb(mem_enb), .mem_addrb(mem_addrb), .mem_doutb(mem_doutb), .mem_rstb(mem_rstb)
    );

    // RAM model: registered read, same-address write forwarded to the read port.
    always @(posedge clk) begin
        if (mem_rstb)
            mem_doutb <= '0;
        else if (mem_enb)
            mem_doutb <= (mem_ena && mem_wea && mem_addra == mem_addrb) ? mem_dina : ram[mem_addrb];
        if (mem_ena && mem_wea)
            ram[mem_addra] <= mem_dina;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = '0;
        mem_doutb = '0;
        rst_n = 1'b0;
        drv0(1'b1, 1'b1, 9'h010, 32'hDEADBEEF);
        drv1(1'b1, 1'b0, 9'h010, 32'h0);
        repeat (2) @(posedge clk);

        // Requests held during reset must be ignored.
        @(negedge clk);
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_mem_ena", mem_ena, 0);
        chk("rst_mem_enb", mem_enb, 0);
        chk("rst_mem_dina", mem_dina, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_mem_rstb", mem_rstb, 1);

        // First cycle out of reset: m0 write is granted immediately.
        @(posedge clk); #1;
        rst_n = 1'b1;
        drv1(1'b0, 1'b0, 9'h0, 32'h0);
        @(negedge clk);
        chk("s1_wr_gnt", m0_gnt, 1);
        chk("s1_mem_wea", mem_wea, 1);
        chk("s1_mem_addra", mem_addra, 32'h010);
        chk("s1_mem_dina", mem_dina, 32'hDEADBEEF);
        chk("s1_mem_enb", mem_enb, 0);
        chk("s1_mem_rstb", mem_rstb, 0);

        @(posedge clk); #1;
        drv0(1'b0, 1'b0, 9'h0, 32'h0);
        drv1(1'b1, 1'b0, 9'h010, 32'h0);
        @(negedge clk);
        chk("s1_rd_gnt", m1_gnt, 1);
        chk("s1_rd_m0_gnt", m0_gnt, 0);
        chk("s1_mem_addrb", mem_addrb, 32'h010);
        chk("s1_mem_ena_idle", mem_ena, 0);

        @(posedge clk); #1;
        drv1(1'b0, 1'b0, 9'h0, 32'h0);
        @(negedge clk);
        chk("s1_m1_rvalid", m1_rvalid, 1);
        chk("s1_m1_rdata", m1_rdata, 32'hDEADBEEF);
        chk("s1_m0_rvalid", m0_rvalid, 0);
        chk("s1_m0_rdata", m0_rdata, 0);

        // Same-cycle read and write to one address: both granted, new data returned.
        @(posedge clk); #1;
        drv0(1'b1, 1'b0, 9'h020, 32'h0);
        drv1(1'b1, 1'b1, 9'h020, 32'h12345678);
        @(negedge clk);
        chk("s2_m0_gnt", m0_gnt, 1);
        chk("s2_m1_gnt", m1_gnt, 1);
        @(posedge clk); #1;
        drv0(1'b0, 1'b0, 9'h0, 32'h0);
        drv1(1'b0, 1'b0, 9'h0, 32'h0);
        @(negedge clk);
        chk("s2_m0_rvalid", m0_rvalid, 1);
        chk("s2_m0_rdata", m0_rdata, 32'h12345678);
        chk("s2_m1_rvalid", m1_rvalid, 0);

        // Read contention for 4 cycles; prev_w tracks who owns the response now due.
        prev_w = -1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k < 4) begin
                drv0(1'b1, 1'b0, 9'h010, 32'h0);
                drv1(1'b1, 1'b0, 9'h020, 32'h0);
            end else begin
                drv0(1'b0, 1'b0, 9'h0, 32'h0);
                drv1(1'b0, 1'b0, 9'h0, 32'h0);
            end
`ifdef ARB_ROUND_ROBIN_EN
            exp_w = k % 2;
`else
            exp_w = 0;
`endif
            if (k == 4) exp_w = -1;
            @(negedge clk);
            chk($sformatf("s3_m0_gnt_%0d", k), m0_gnt, exp_w == 0);
            chk($sformatf("s3_m1_gnt_%0d", k), m1_gnt, exp_w == 1);
            chk($sformatf("s3_m0_rvalid_%0d", k), m0_rvalid, prev_w == 0);
            chk($sformatf("s3_m1_rvalid_%0d", k), m1_rvalid, prev_w == 1);
            chk($sformatf("s3_m0_rdata_%0d", k), m0_rdata, (prev_w == 0) ? 32'hDEADBEEF : 32'h0);
            chk($sformatf("s3_m1_rdata_%0d", k), m1_rdata, (prev_w == 1) ? 32'h12345678 : 32'h0);
            prev_w = exp_w;
        end

        // Write contention: write pointer is still at master 0 in either build.
        @(posedge clk); #1;
        drv0(1'b1, 1'b1, 9'h030, 32'hAAAA0000);
        drv1(1'b1, 1'b1, 9'h031, 32'h5555FFFF);
        @(negedge clk);
        chk("wc_m0_gnt", m0_gnt, 1);
        chk("wc_m1_gnt", m1_gnt, 0);
        chk("wc_mem_dina", mem_dina, 32'hAAAA0000);
        chk("wc_mem_addra", mem_addra, 32'h030);

        // Reset lands between an m1 read grant and its response.
        @(posedge clk); #1;
        drv0(1'b0, 1'b0, 9'h0, 32'h0);
        drv1(1'b1, 1'b0, 9'h010, 32'h0);
        @(negedge clk);
        chk("s5_pre_gnt", m1_gnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_gnt", m1_gnt, 0);
        chk("s5_rst_enb", mem_enb, 0);
        chk("s5_rst_rstb", mem_rstb, 1);
        @(posedge clk); #1;
        chk("s5_rst_rvalid", m1_rvalid, 0);
        chk("s5_rst_rdata", m1_rdata, 0);
        chk("s5_rst_addrb", mem_addrb, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("s5_rel_gnt", m1_gnt, 1);
        chk("s5_rel_rvalid", m1_rvalid, 0);
        chk("s5_rel_rstb", mem_rstb, 0);
        @(posedge clk); #1;
        drv1(1'b0, 1'b0, 9'h0, 32'h0);
        @(negedge clk);
        chk("s5_post_rvalid", m1_rvalid, 1);
        chk("s5_post_rdata", m1_rdata, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 9, word address width (512 words).
- DATA_W, 32, data width.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- mN_req  in  1  master N (N=0,1) access request.
- mN_we  in  1  master N write (1) / read (0).
- mN_addr  in  ADDR_W  master N word address.
- mN_wdata  in  DATA_W  master N write data.
- mN_gnt  out  1  master N request accepted this cycle.
- mN_rvalid  out  1  master N read data valid.
- mN_rdata  out  DATA_W  master N read data.
- mem_ena, mem_wea  out  1  memory write-port enable and write strobe.
- mem_addra  out  ADDR_W  memory write-port address.
- mem_dina  out  DATA_W  memory write-port data.
- mem_enb  out  1  memory read-port enable.
- mem_addrb  out  ADDR_W  memory read-port address.
- mem_doutb  in  DATA_W  memory read data, registered, 1-cycle latency.
- mem_rstb  out  1  memory read-port reset, active-high, equal to !rst_n.

Function
REQ-003 Write and read ports SHALL be arbitrated independently: a write and a read from different masters SHALL both be granted in the same cycle.
REQ-004 Grants SHALL be combinational from the req, we and priority state; a request is consumed in the cycle where req=1 and gnt=1.
REQ-005 At most one master SHALL be granted per port per cycle; gnt SHALL be 0 whenever req=0.
REQ-006 A granted write SHALL drive mem_ena=mem_wea=1 with that master's addr and wdata in the same cycle; with no granted write, mem_ena=mem_wea=0 and mem_addra/mem_dina=0.
REQ-007 A granted read SHALL drive mem_enb=1 and mem_addrb in the same cycle; with no granted read, mem_enb=0 and mem_addrb=0.
REQ-008 A read response pipeline register SHALL hold {pending, owner}; on the cycle after a read grant, only the owner's rvalid SHALL be 1 and its rdata SHALL equal mem_doutb.
REQ-009 A non-owner's rdata SHALL be 0, and rvalid SHALL be 0 for any master with no pending read.
REQ-010 Back-to-back reads SHALL sustain one grant per cycle with no bubble.
REQ-011 A same-cycle write and read to the same address SHALL return the new write data, supplied by the memory's write-through path; the arbiter SHALL NOT reorder the two accesses.
REQ-012 Under contention (both masters request the same port), the winner SHALL be selected per REQ-017/REQ-018.

Reset
REQ-013 While rst_n=0, all gnt, rvalid, rdata and mem_* outputs SHALL be 0, except mem_rstb, which SHALL be 1.
REQ-014 Reset SHALL clear the pending flag, owner, and both priority pointers (pointer=master 0).
REQ-015 A read granted in the cycle reset asserts SHALL be discarded; no rvalid SHALL follow reset release.
REQ-016 The first request SHALL be grantable in the first cycle with rst_n=1.

Configuration
REQ-017 With ARB_ROUND_ROBIN_EN defined, each port SHALL keep a 1-bit priority pointer.
- Contention SHALL grant the pointed master.
- The pointer SHALL then move to the loser.
- The pointer SHALL be unchanged when there is no contention.
REQ-018 Without ARB_ROUND_ROBIN_EN, master 0 SHALL always win contention on both ports, and no pointer registers SHALL exist.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- m0 write addr 0x010 data 0xDEADBEEF, next cycle m1 read 0x010 -> m1_gnt=1, m1_rvalid=1 one cycle later with m1_rdata=0xDEADBEEF, m0_rvalid=0.
- m0 read 0x020 and m1 write 0x020 data 0x12345678 in the same cycle -> both gnt=1, m0_rdata=0x12345678 on the next cycle.
- Both masters read continuously for 4 cycles with RR enabled -> grants alternate m0,m1,m0,m1, each rvalid 1 cycle after its gnt, never both rvalid in one cycle.
- Same contention with the macro undefined -> m0_gnt=1 all 4 cycles, m1_gnt=0.
- m1 read granted, rst_n pulled low mid-cycle before the response -> m1_rvalid=0 throughout, all outputs 0, mem_rstb=1; after release, the first m1 read is granted immediately.
